// File: rtl/fifo_n_pkg.sv
// Shared helpers for the parametrised FIFO: width derivation and wrapping
// pointer increment for depths that need not be a power of two.
package fifo_n_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int ptr_inc(input int ptr, input int depth);
        int nxt;
        if (ptr == depth - 1) begin
            nxt = 0;
        end else begin
            nxt = ptr + 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fifo_n_if.sv
// Producer/consumer handshake bundle of fifo_n; master drives requests,
// slave (the FIFO) returns data, acknowledges and status.
interface fifo_n_if #(
    parameter int WIDTH = 4,
    parameter int CW    = 3
);
    logic             flush;
    logic             enque;
    logic [WIDTH-1:0] enque_data;
    logic             deque;
    logic [WIDTH-1:0] deque_data;
    logic             enqued;
    logic             dequed;
    logic             is_full;
    logic             is_empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, enque, enque_data, deque,
        input  deque_data, enqued, dequed, is_full, is_empty,
               almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, enque, enque_data, deque,
        output deque_data, enqued, dequed, is_full, is_empty,
               almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_n_ram.sv
// DEPTH x WIDTH storage with one synchronous write port and a registered
// read port whose output register holds its value between reads.
module fifo_n_ram #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [PW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [PW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    // Storage array write; contents survive reset and flush.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read data next-value: load on accepted dequeue, otherwise hold.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Read data register.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_q <= {WIDTH{1'b0}};
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/fifo_n.sv
// Parametrised synchronous FIFO with registered acknowledges, occupancy
// count, programmable level flags, flush and sticky error flags.
import fifo_n_pkg::*;

module fifo_n #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic     clock,
    input  logic     reset,
    fifo_n_if.slave  bus
);
    localparam int            CW       = clog2(DEPTH + 1);
    localparam int            PW       = clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          enqued_q, enqued_d;
    logic          dequed_q, dequed_d;
    logic          is_full_q, is_full_d;
    logic          is_empty_q, is_empty_d;
    logic          almost_full_q, almost_full_d;
    logic          almost_empty_q, almost_empty_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          enq_ok;
    logic          deq_ok;

    // Acceptance uses registered flags only, so full-with-deque still rejects the enqueue.
    always_comb begin
        enq_ok = bus.enque && !is_full_q && !bus.flush;
        deq_ok = bus.deque && !is_empty_q && !bus.flush;
    end

    // Next-state for pointers, occupancy, acknowledges and error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        enqued_d    = enq_ok;
        dequed_d    = deq_ok;
        if (bus.flush) begin
            wr_ptr_d    = {PW{1'b0}};
            rd_ptr_d    = {PW{1'b0}};
            count_d     = {CW{1'b0}};
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (enq_ok) begin
                wr_ptr_d = PW'(ptr_inc(int'(wr_ptr_q), DEPTH));
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_ok) begin
                rd_ptr_d = PW'(ptr_inc(int'(rd_ptr_q), DEPTH));
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({enq_ok, deq_ok})
                2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
                default: count_d = count_q;
            endcase
            overflow_d  = overflow_q  | (bus.enque & is_full_q);
            underflow_d = underflow_q | (bus.deque & is_empty_q);
        end
    end

    // Status flags are decoded from the next count so they register alongside it.
    always_comb begin
        is_full_d      = (count_d == FULL_CNT);
        is_empty_d     = (count_d == {CW{1'b0}});
        almost_full_d  = (int'(count_d) >= AF_LEVEL);
        almost_empty_d = (int'(count_d) <= AE_LEVEL);
    end

    // Control and status registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q       <= {PW{1'b0}};
            rd_ptr_q       <= {PW{1'b0}};
            count_q        <= {CW{1'b0}};
            enqued_q       <= 1'b0;
            dequed_q       <= 1'b0;
            is_full_q      <= 1'b0;
            is_empty_q     <= 1'b1;
            almost_full_q  <= (AF_LEVEL == 0);
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            enqued_q       <= enqued_d;
            dequed_q       <= dequed_d;
            is_full_q      <= is_full_d;
            is_empty_q     <= is_empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    fifo_n_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (enq_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.enque_data),
        .rd_en   (deq_ok),
        .rd_addr (rd_ptr_q),
        .rd_data (bus.deque_data)
    );

    assign bus.enqued       = enqued_q;
    assign bus.dequed       = dequed_q;
    assign bus.count        = count_q;
    assign bus.is_full      = is_full_q;
    assign bus.is_empty     = is_empty_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule
